// File: rtl/cla_nibble_sched.sv
// Two-requester scheduler around a shared 4-bit carry-lookahead adder.
// A WIDTH-bit sum is built one nibble per cycle, LSB nibble first, with the carry held in a register.
module cla_nibble_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic             i_req0_cin,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic             i_req1_cin,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_sum,
  output logic             o_res_cout,
  output logic             o_res_id,
  output logic             o_busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_id;
  logic             r_last;   // id granted most recently; resets to 1 so req0 wins the first tie

  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [3:0]       w_a_nib [NIB];
  logic [3:0]       w_b_nib [NIB];
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_nib_sum;

  assign w_idle   = (r_state == S_IDLE);
  assign w_grant0 = w_idle & i_req0_valid & (~i_req1_valid | r_last);
  assign w_grant1 = w_idle & i_req1_valid & (~i_req0_valid | ~r_last);
  assign w_accept = w_grant0 | w_grant1;

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_res_valid  = (r_state == S_DONE);
  assign o_busy       = ~w_idle;
  assign o_res_sum    = r_sum;
  assign o_res_cout   = r_cout;
  assign o_res_id     = r_id;

  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
    assign w_a_nib[gi] = r_a[4*gi +: 4];
    assign w_b_nib[gi] = r_b[4*gi +: 4];
  end

  // Two-level lookahead: every carry is a flat function of g, p and the incoming carry.
  assign w_g = w_a_nib[r_cnt] & w_b_nib[r_cnt];
  assign w_p = w_a_nib[r_cnt] ^ w_b_nib[r_cnt];
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & r_carry);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_carry);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
  assign w_nib_sum = w_p ^ w_c[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant1 ? i_req1_a   : i_req0_a;
            r_b     <= w_grant1 ? i_req1_b   : i_req0_b;
            r_carry <= w_grant1 ? i_req1_cin : i_req0_cin;
            r_id    <= w_grant1;
            r_last  <= w_grant1;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[4*r_cnt +: 4] <= w_nib_sum;
          r_carry             <= w_c[4];
          r_cnt               <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_cout  <= w_c[4];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_sched.sv
// Self-checking bench for cla_nibble_sched (WIDTH=16): directed table, hand sequences
// for stall/reset/round-robin, and random ops against an arithmetic reference model.
module tb_cla_nibble_sched;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_req0_valid, i_req0_cin, i_req1_valid, i_req1_cin, i_res_ready;
  logic [W-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic         o_req0_ready, o_req1_ready, o_res_valid, o_res_cout, o_res_id, o_busy;
  logic [W-1:0] o_res_sum;

  int n_vec = 0;
  int n_err = 0;
  bit model_last;   // requester granted most recently, as the reference model sees it

  typedef struct {
    bit         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       cin;
    logic [W-1:0] sum;
    logic       cout;
  } vec_t;

  vec_t tbl[7];

  cla_nibble_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_cin(i_req0_cin),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_cin(i_req1_cin),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_sum(o_res_sum), .o_res_cout(o_res_cout), .o_res_id(o_res_id),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin);
    int   w;
    logic rdy;
    if (id) begin
      i_req1_valid = 1'b1; i_req1_a = a; i_req1_b = b; i_req1_cin = cin;
    end else begin
      i_req0_valid = 1'b1; i_req0_a = a; i_req0_b = b; i_req0_cin = cin;
    end
    #1;
    w   = 0;
    rdy = id ? o_req1_ready : o_req0_ready;
    while (!rdy && w < 32) begin
      tick();
      w++;
      rdy = id ? o_req1_ready : o_req0_ready;
    end
    check("accept_ready", {31'd0, rdy}, 32'd1);
    check("other_ready", {31'd0, id ? o_req0_ready : o_req1_ready}, 32'd0);
    tick();
    // Scramble operands after accept: the captured values must be what gets summed.
    if (id) begin
      i_req1_valid = 1'b0; i_req1_a = W'($urandom); i_req1_b = W'($urandom); i_req1_cin = 1'($urandom);
    end else begin
      i_req0_valid = 1'b0; i_req0_a = W'($urandom); i_req0_b = W'($urandom); i_req0_cin = 1'($urandom);
    end
    model_last = id;
  endtask

  task automatic await_result(input bit id, input logic [W-1:0] es, input logic ec,
                              input string tag);
    int lat;
    lat = 0;
    while (!o_res_valid && lat < 32) begin
      tick();
      lat++;
    end
    check("latency", lat, NIB);
    check("res_sum", {16'd0, o_res_sum}, {16'd0, es});
    check("res_cout", {31'd0, o_res_cout}, {31'd0, ec});
    check("res_id", {31'd0, o_res_id}, {31'd0, id});
    $display("[%s] req%0d sum=%h cout=%0b latency=%0d", tag, id, o_res_sum, o_res_cout, lat);
  endtask

  task automatic release_result();
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    check("res_valid_drop", {31'd0, o_res_valid}, 32'd0);
    check("busy_drop", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    logic [W:0]   exp;
    logic [W-1:0] opa [2];
    logic [W-1:0] opb [2];
    logic         opc [2];
    bit           winner;
    logic [W-1:0] held_sum;

    tbl[0] = '{id: 1'b0, a: 16'h00FF, b: 16'h0001, cin: 1'b0, sum: 16'h0100, cout: 1'b0};
    tbl[1] = '{id: 1'b1, a: 16'hA5A5, b: 16'h5A5A, cin: 1'b1, sum: 16'h0000, cout: 1'b1};
    tbl[2] = '{id: 1'b1, a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
    tbl[3] = '{id: 1'b0, a: 16'h0000, b: 16'h0000, cin: 1'b0, sum: 16'h0000, cout: 1'b0};
    tbl[4] = '{id: 1'b1, a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1};
    tbl[5] = '{id: 1'b0, a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
    tbl[6] = '{id: 1'b1, a: 16'h0FFF, b: 16'h0001, cin: 1'b0, sum: 16'h1000, cout: 1'b0};

    // Reset with random inputs
    rst_n = 1'b0;
    i_req0_valid = 1'($urandom); i_req1_valid = 1'($urandom); i_res_ready = 1'($urandom);
    i_req0_a = W'($urandom); i_req0_b = W'($urandom); i_req0_cin = 1'($urandom);
    i_req1_a = W'($urandom); i_req1_b = W'($urandom); i_req1_cin = 1'($urandom);
    repeat (3) tick();
    check("reset_res_valid", {31'd0, o_res_valid}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_sum", {16'd0, o_res_sum}, 32'd0);
    check("reset_cout_id", {30'd0, o_res_cout, o_res_id}, 32'd0);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_res_ready = 1'b0;
    #1;
    check("reset_readys", {30'd0, o_req0_ready, o_req1_ready}, 32'd0);
    #2;
    rst_n = 1'b1;
    model_last = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_accept(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin);
      await_result(tbl[i].id, tbl[i].sum, tbl[i].cout, "table");
      release_result();
    end

    // res_ready withheld for 3 cycles while the other requester waits
    do_accept(1'b0, 16'h1111, 16'h2222, 1'b0);
    i_req1_valid = 1'b1; i_req1_a = 16'h0F0F; i_req1_b = 16'h00F1; i_req1_cin = 1'b1;
    await_result(1'b0, 16'h3333, 1'b0, "stall");
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", {31'd0, o_res_valid}, 32'd1);
      check("stall_sum", {16'd0, o_res_sum}, 32'h3333);
      check("stall_id", {31'd0, o_res_id}, 32'd0);
      check("stall_readys", {30'd0, o_req0_ready, o_req1_ready}, 32'd0);
    end
    i_res_ready = 1'b1;
    #1;
    check("exit_cycle_ready", {31'd0, o_req1_ready}, 32'd0);
    tick();
    i_res_ready = 1'b0;
    check("stall_drop", {31'd0, o_res_valid}, 32'd0);
    check("sum_hold_idle", {16'd0, o_res_sum}, 32'h3333);
    check("ready_after_exit", {31'd0, o_req1_ready}, 32'd1);
    do_accept(1'b1, 16'h0F0F, 16'h00F1, 1'b1);
    await_result(1'b1, 16'h1001, 1'b0, "stall_next");
    release_result();

    // Reset asserted in the second RUN cycle
    do_accept(1'b0, 16'hBEEF, 16'h4321, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrun_res_valid", {31'd0, o_res_valid}, 32'd0);
    check("midrun_busy", {31'd0, o_busy}, 32'd0);
    check("midrun_sum", {16'd0, o_res_sum}, 32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    model_last = 1'b1;
    tick();
    do_accept(1'b0, 16'h1234, 16'h1111, 1'b0);
    await_result(1'b0, 16'h2345, 1'b0, "post_reset");
    release_result();

    // Both requesters valid continuously from reset: grants alternate 0,1,0,1,...
    rst_n = 1'b0;
    tick();
    #2;
    rst_n = 1'b1;
    model_last = 1'b1;
    tick();
    for (int r = 0; r < 2; r++) begin
      opa[r] = W'($urandom); opb[r] = W'($urandom); opc[r] = 1'($urandom);
    end
    i_req0_a = opa[0]; i_req0_b = opb[0]; i_req0_cin = opc[0];
    i_req1_a = opa[1]; i_req1_b = opb[1]; i_req1_cin = opc[1];
    i_req0_valid = 1'b1; i_req1_valid = 1'b1; i_res_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      int w;
      w = 0;
      while (!(o_req0_ready || o_req1_ready) && w < 32) begin
        tick();
        w++;
      end
      check("rr_some_grant", {31'd0, o_req0_ready | o_req1_ready}, 32'd1);
      check("rr_one_grant", {31'd0, o_req0_ready & o_req1_ready}, 32'd0);
      winner = o_req1_ready;
      check("rr_grant", {31'd0, winner}, {31'd0, ~model_last});
      exp = model_add(opa[winner], opb[winner], opc[winner]);
      tick();
      model_last = winner;
      opa[winner] = W'($urandom); opb[winner] = W'($urandom); opc[winner] = 1'($urandom);
      if (winner) begin
        i_req1_a = opa[1]; i_req1_b = opb[1]; i_req1_cin = opc[1];
      end else begin
        i_req0_a = opa[0]; i_req0_b = opb[0]; i_req0_cin = opc[0];
      end
      await_result(winner, exp[W-1:0], exp[W], "round_robin");
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    tick();
    i_res_ready = 1'b0;
    tick();

    // Random single-requester ops against the arithmetic model
    for (int k = 0; k < 30; k++) begin
      bit           id;
      logic [W-1:0] a, b;
      logic         cin;
      int           stall;
      id = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      stall = int'($urandom_range(0, 2));
      exp = model_add(a, b, cin);
      do_accept(id, a, b, cin);
      await_result(id, exp[W-1:0], exp[W], "random");
      held_sum = exp[W-1:0];
      for (int s = 0; s < stall; s++) begin
        tick();
        check("rand_hold_sum", {16'd0, o_res_sum}, {16'd0, held_sum});
        check("rand_hold_valid", {31'd0, o_res_valid}, 32'd1);
      end
      release_result();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
